// File: rtl/controlador_matriz_pkg.sv
// Shared types and column helper for the 5x7 LED-matrix scheduler.
// CONTROLADOR_MATRIZ_ROLAGEM_EN enables the column-by-column scroll-in state.
package pacote_matriz;

    localparam int unsigned NUM_COLUNAS    = 5;
    localparam int unsigned LARGURA_COLUNA = 7;
    localparam int unsigned LARGURA_FRAME  = NUM_COLUNAS * LARGURA_COLUNA;

`ifdef CONTROLADOR_MATRIZ_ROLAGEM_EN
    typedef enum logic [1:0] {OCIOSO, ROLANDO, EXIBINDO} estado_t;
`else
    typedef enum logic [1:0] {OCIOSO, EXIBINDO} estado_t;
`endif

    // Column 0 sits in the most significant bits of the frame.
    function automatic logic [LARGURA_COLUNA-1:0] coluna(
        input logic [LARGURA_FRAME-1:0] frame,
        input logic [2:0]               idx
    );
        logic [LARGURA_COLUNA-1:0] w_col;
        case (idx)
            3'd0:    w_col = frame[34:28];
            3'd1:    w_col = frame[27:21];
            3'd2:    w_col = frame[20:14];
            3'd3:    w_col = frame[13:7];
            3'd4:    w_col = frame[6:0];
            default: w_col = '0;
        endcase
        return w_col;
    endfunction

endpackage

// File: rtl/controlador_matriz_arbitro.sv
// Two-way round-robin arbiter with registered one-cycle acknowledges.
// o_last_grant is 1 when B holds the most recent grant (reset value).
module arbitro_rr_2 (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_permitido,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_ack_a,
    output logic o_ack_b,
    output logic o_last_grant
);

    logic r_ack_a;
    logic r_ack_b;
    logic r_last_b;
    logic w_conc_a;
    logic w_conc_b;

    always_comb begin
        w_conc_a = 1'b0;
        w_conc_b = 1'b0;
        if (i_permitido) begin
            if (i_req_a && i_req_b) begin
                w_conc_a = r_last_b;
                w_conc_b = !r_last_b;
            end else begin
                w_conc_a = i_req_a;
                w_conc_b = i_req_b;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ack_a  <= 1'b0;
            r_ack_b  <= 1'b0;
            r_last_b <= 1'b1;
        end else begin
            r_ack_a <= w_conc_a;
            r_ack_b <= w_conc_b;
            if (w_conc_a) begin
                r_last_b <= 1'b0;
            end else if (w_conc_b) begin
                r_last_b <= 1'b1;
            end
        end
    end

    assign o_ack_a      = r_ack_a;
    assign o_ack_b      = r_ack_b;
    assign o_last_grant = r_last_b;

endmodule

// File: rtl/controlador_matriz.sv
// Frame scheduler for the 5x7 LED-matrix driver: arbitration, minimum hold, optional scroll-in.
// Define CONTROLADOR_MATRIZ_ROLAGEM_EN to scroll frames in; otherwise frames load at once.
module controlador_matriz
    import pacote_matriz::*;
#(
    parameter int unsigned TICKS_PASSO  = 50,
    parameter int unsigned EXIBICAO_MIN = 200
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_tick,
    input  logic                      i_req_a,
    input  logic [LARGURA_FRAME-1:0]  i_frame_a,
    output logic                      o_ack_a,
    input  logic                      i_req_b,
    input  logic [LARGURA_FRAME-1:0]  i_frame_b,
    output logic                      o_ack_b,
    output logic [LARGURA_COLUNA-1:0] o_mapa0,
    output logic [LARGURA_COLUNA-1:0] o_mapa1,
    output logic [LARGURA_COLUNA-1:0] o_mapa2,
    output logic [LARGURA_COLUNA-1:0] o_mapa3,
    output logic [LARGURA_COLUNA-1:0] o_mapa4,
    output logic                      o_enable,
    output logic                      o_ocupado
);

    localparam logic [15:0] EXIB_MIN_W = 16'(EXIBICAO_MIN);

    estado_t                   r_estado;
    estado_t                   w_estado_prox;
    logic [LARGURA_COLUNA-1:0] r_mapa [NUM_COLUNAS];
    logic [15:0]               r_exib;
    logic                      r_enable;
    logic                      w_ack_a;
    logic                      w_ack_b;
    logic                      w_last_grant;
    logic                      w_permitido;
    logic                      w_aceite;
    logic                      w_exib_cheio;
    logic [LARGURA_FRAME-1:0]  w_frame_sel;

    assign w_exib_cheio = (r_exib >= EXIB_MIN_W);
    assign w_aceite     = w_ack_a || w_ack_b;
    // last_grant flips on the same edge the ack rises, so it names the frame being captured.
    assign w_frame_sel  = w_last_grant ? i_frame_b : i_frame_a;

    // No new grant while an ack is in flight; the state only moves on the ack cycle.
    assign w_permitido = ((r_estado == OCIOSO) || ((r_estado == EXIBINDO) && w_exib_cheio))
                         && !w_ack_a && !w_ack_b;

    arbitro_rr_2 u_arbitro (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_permitido  (w_permitido),
        .i_req_a      (i_req_a),
        .i_req_b      (i_req_b),
        .o_ack_a      (w_ack_a),
        .o_ack_b      (w_ack_b),
        .o_last_grant (w_last_grant)
    );

`ifdef CONTROLADOR_MATRIZ_ROLAGEM_EN
    localparam logic [7:0] DIV_ULT = 8'(TICKS_PASSO - 1);

    logic [7:0]               r_div;
    logic [2:0]               r_passo;
    logic [LARGURA_FRAME-1:0] r_pendente;
    logic                     w_passo_agora;

    assign w_passo_agora = (r_estado == ROLANDO) && i_tick && (r_div == DIV_ULT);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_div      <= 8'd0;
            r_passo    <= 3'd0;
            r_pendente <= '0;
        end else if (w_aceite) begin
            r_div      <= 8'd0;
            r_passo    <= 3'd0;
            r_pendente <= w_frame_sel;
        end else if ((r_estado == ROLANDO) && i_tick) begin
            if (r_div == DIV_ULT) begin
                r_div   <= 8'd0;
                r_passo <= (r_passo == 3'd4) ? 3'd0 : r_passo + 3'd1;
            end else begin
                r_div <= r_div + 8'd1;
            end
        end
    end
`endif

    always_comb begin
        w_estado_prox = r_estado;
        unique case (r_estado)
            OCIOSO, EXIBINDO: begin
                if (w_aceite) begin
`ifdef CONTROLADOR_MATRIZ_ROLAGEM_EN
                    w_estado_prox = ROLANDO;
`else
                    w_estado_prox = EXIBINDO;
`endif
                end
            end
`ifdef CONTROLADOR_MATRIZ_ROLAGEM_EN
            ROLANDO: begin
                if (w_passo_agora && (r_passo == 3'd4)) begin
                    w_estado_prox = EXIBINDO;
                end
            end
`endif
            default: w_estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_COLUNAS; i++) begin
                r_mapa[i] <= '0;
            end
`ifdef CONTROLADOR_MATRIZ_ROLAGEM_EN
        end else if (w_passo_agora) begin
            for (int i = 0; i < NUM_COLUNAS - 1; i++) begin
                r_mapa[i] <= r_mapa[i+1];
            end
            r_mapa[NUM_COLUNAS-1] <= coluna(r_pendente, r_passo);
`else
        end else if (w_aceite) begin
            for (int i = 0; i < NUM_COLUNAS; i++) begin
                r_mapa[i] <= coluna(w_frame_sel, 3'(i));
            end
`endif
        end
    end

    // Hold counter restarts on every accept and only runs while the frame is fully shown.
    always_ff @(posedge i_clock) begin
        if (i_reset || w_aceite || (r_estado != EXIBINDO)) begin
            r_exib <= 16'd0;
        end else if (i_tick && !w_exib_cheio) begin
            r_exib <= r_exib + 16'd1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_enable <= 1'b0;
        end else if (w_aceite) begin
            r_enable <= 1'b1;
        end
    end

`ifdef CONTROLADOR_MATRIZ_ROLAGEM_EN
    assign o_ocupado = (r_estado == ROLANDO) || ((r_estado == EXIBINDO) && !w_exib_cheio);
`else
    assign o_ocupado = (r_estado == EXIBINDO) && !w_exib_cheio;
`endif

    assign o_ack_a  = w_ack_a;
    assign o_ack_b  = w_ack_b;
    assign o_enable = r_enable;
    assign o_mapa0  = r_mapa[0];
    assign o_mapa1  = r_mapa[1];
    assign o_mapa2  = r_mapa[2];
    assign o_mapa3  = r_mapa[3];
    assign o_mapa4  = r_mapa[4];

endmodule

// File: tb/tb_controlador_matriz.sv
// Self-checking bench for controlador_matriz: vector table, directed corner cases, random vs model.
// Follows CONTROLADOR_MATRIZ_ROLAGEM_EN the same way the design does.
module tb_controlador_matriz;

    localparam int unsigned TP  = 2;
    localparam int unsigned MIN = 4;
`ifdef CONTROLADOR_MATRIZ_ROLAGEM_EN
    localparam bit ROLA   = 1'b1;
    localparam int ROLL   = 5 * TP;
    localparam int RST_AT = 6;
`else
    localparam bit ROLA   = 1'b0;
    localparam int ROLL   = 0;
    localparam int RST_AT = 2;
`endif

    localparam logic [34:0] FA = 35'h1_2345_6789;
    localparam logic [34:0] FB = 35'h7_0F0F_1E3C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [34:0] fa = '0;
    logic [34:0] fb = '0;
    logic        ack_a, ack_b, en, ocup;
    logic [6:0]  m0, m1, m2, m3, m4;
    logic [34:0] mapas;

    assign mapas = {m0, m1, m2, m3, m4};

    always #5 clk = ~clk;

    controlador_matriz #(
        .TICKS_PASSO  (TP),
        .EXIBICAO_MIN (MIN)
    ) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_tick    (tick),
        .i_req_a   (req_a),
        .i_frame_a (fa),
        .o_ack_a   (ack_a),
        .i_req_b   (req_b),
        .i_frame_b (fb),
        .o_ack_b   (ack_b),
        .o_mapa0   (m0),
        .o_mapa1   (m1),
        .o_mapa2   (m2),
        .o_mapa3   (m3),
        .o_mapa4   (m4),
        .o_enable  (en),
        .o_ocupado (ocup)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nome, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = nothing shown yet, 1 = scrolling, 2 = fully shown.
    int         md_mode;
    logic [6:0] md_cols [5];
    logic [6:0] md_fila [$];
    int         md_ticks;
    bit         md_last_b, md_ack_a, md_ack_b, md_en;

    function automatic logic [6:0] col_of(input logic [34:0] f, input int i);
        logic [34:0] t;
        t = f << (7 * i);
        return t[34:28];
    endfunction

    task automatic model_step(input bit r, input bit t, input bit ra, input bit rb,
                              input logic [34:0] a, input logic [34:0] b);
        bit          allowed, wa, wb;
        logic [34:0] f;
        if (r) begin
            md_mode = 0;
            foreach (md_cols[i]) md_cols[i] = '0;
            md_fila.delete();
            md_ticks  = 0;
            md_last_b = 1'b1;
            md_ack_a  = 1'b0;
            md_ack_b  = 1'b0;
            md_en     = 1'b0;
            return;
        end
        allowed = (md_mode == 0 || (md_mode == 2 && md_ticks >= int'(MIN)))
                  && !md_ack_a && !md_ack_b;
        wa = allowed && ra && (!rb || md_last_b);
        wb = allowed && rb && (!ra || !md_last_b);
        if (md_ack_a || md_ack_b) begin
            f = md_ack_a ? a : b;
            md_en    = 1'b1;
            md_ticks = 0;
            if (ROLA) begin
                md_fila.delete();
                for (int i = 0; i < 5; i++) md_fila.push_back(col_of(f, i));
                md_mode = 1;
            end else begin
                for (int i = 0; i < 5; i++) md_cols[i] = col_of(f, i);
                md_mode = 2;
            end
        end else if (md_mode == 1 && t) begin
            md_ticks++;
            if (md_ticks % int'(TP) == 0) begin
                for (int i = 0; i < 4; i++) md_cols[i] = md_cols[i+1];
                md_cols[4] = md_fila.pop_front();
                if (md_fila.size() == 0) begin
                    md_mode  = 2;
                    md_ticks = 0;
                end
            end
        end else if (md_mode == 2 && t) begin
            md_ticks++;
        end
        md_ack_a = wa;
        md_ack_b = wb;
        if (wa) md_last_b = 1'b0;
        else if (wb) md_last_b = 1'b1;
    endtask

    task automatic compare_model();
        logic exp_ocup;
        exp_ocup = (md_mode == 1) || (md_mode == 2 && md_ticks < int'(MIN));
        check("modelo", {ack_a, ack_b, en, ocup, mapas},
              {md_ack_a, md_ack_b, md_en, exp_ocup,
               md_cols[0], md_cols[1], md_cols[2], md_cols[3], md_cols[4]});
    endtask

    task automatic ciclo();
        @(posedge clk);
        model_step(rst, tick, req_a, req_b, fa, fb);
        #1;
        compare_model();
    endtask

    typedef struct {
        int          edge_n;
        logic [3:0]  flags;   // {ack_a, ack_b, ocupado, enable}
        logic [34:0] mapa;
        string       nome;
    } vec_t;

    initial begin
        vec_t        tab [9];
        int          k;
        logic [34:0] fr;

        tab[0] = '{1,             4'b1000, 35'h0,          "tie_a_first"};
        tab[1] = '{2,             4'b0011, ROLA ? 35'h0 : FA, "ack_cycle_after"};
        tab[2] = '{2 + ROLL,      4'b0011, FA,             "a_fully_shown"};
        tab[3] = '{5 + ROLL,      4'b0011, FA,             "hold_not_expired"};
        tab[4] = '{6 + ROLL,      4'b0001, FA,             "hold_expired"};
        tab[5] = '{7 + ROLL,      4'b0101, FA,             "b_acked_after_hold"};
        tab[6] = '{8 + 2 * ROLL,  4'b0011, FB,             "b_fully_shown"};
        tab[7] = '{12 + 2 * ROLL, 4'b0001, FB,             "b_hold_expired"};
        tab[8] = '{13 + 2 * ROLL, 4'b1001, FB,             "next_tie_a"};

        // Reset held three cycles.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) ciclo();
        check("reset_mapas", mapas, 35'h0);
        check("reset_enable", en, 1'b0);
        check("reset_acks", {ack_a, ack_b}, 2'b00);
        check("reset_ocupado", ocup, 1'b0);

        // Both requesters from reset, tick every cycle.
        rst = 1'b0; tick = 1'b1; req_a = 1'b1; req_b = 1'b1; fa = FA; fb = FB;
        for (k = 1; k <= 13 + 2 * ROLL; k++) begin
            ciclo();
            foreach (tab[j]) begin
                if (tab[j].edge_n == k) begin
                    check({tab[j].nome, "_flags"}, {ack_a, ack_b, ocup, en}, tab[j].flags);
                    check({tab[j].nome, "_mapa"}, mapas, tab[j].mapa);
                end
            end
            if (ack_a) req_a = 1'b0;
            if (ack_b) req_b = 1'b0;
            if (k == 8 + 2 * ROLL) begin
                req_a = 1'b1;
                req_b = 1'b1;
            end
        end

        // Single A frame; B raised right after A's ack must wait for scroll plus hold.
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        ciclo();
        rst = 1'b0; req_a = 1'b1; fa = FA;
        ciclo();
        k = 1;
        check("single_ack_a", ack_a, 1'b1);
        req_a = 1'b0; req_b = 1'b1; fb = FB;
`ifdef CONTROLADOR_MATRIZ_ROLAGEM_EN
        ciclo(); k++;
        for (int s = 1; s <= 5; s++) begin
            ciclo(); ciclo(); k += 2;
            check("scroll_step", mapas, FA >> (7 * (5 - s)));
            check("scroll_ocupado", ocup, 1'b1);
        end
`else
        check("no_intermediate", mapas, 35'h0);
        ciclo(); k++;
        check("full_load", mapas, FA);
`endif
        check("enable_on", en, 1'b1);
        while (k < 60 && !ack_b) begin
            ciclo(); k++;
            if (k <= 5 + ROLL) check("ocupado_hold", ocup, 1'b1);
        end
        check("ack_b_wait_edge", k, 7 + ROLL);
        check("ack_b_seen", ack_b, 1'b1);
        req_b = 1'b0;

        // Reset in the middle of a frame, then a normal accept.
        rst = 1'b1;
        ciclo();
        rst = 1'b0; req_a = 1'b1; fa = FB;
        for (int i = 0; i < RST_AT; i++) begin
            ciclo();
            if (ack_a) req_a = 1'b0;
        end
        rst = 1'b1;
        ciclo();
        check("midreset_mapas", mapas, 35'h0);
        check("midreset_flags", {ack_a, ack_b, ocup, en}, 4'b0000);
        rst = 1'b0; req_a = 1'b1; fa = FA;
        ciclo();
        check("ack_after_reset", ack_a, 1'b1);
        req_a = 1'b0;
        ciclo();

        // Random traffic against the model; frames are sometimes re-sent unchanged.
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 399) == 0);
            tick = ($urandom_range(0, 2) == 0);
            if (md_ack_a) req_a = 1'b0;
            if (md_ack_b) req_b = 1'b0;
            if (!req_a && $urandom_range(0, 7) == 0) begin
                req_a = 1'b1;
                if ($urandom_range(0, 3) != 0) begin
                    fr = 35'({$urandom(), $urandom()});
                    fa = fr;
                end
            end
            if (!req_b && $urandom_range(0, 7) == 0) begin
                req_b = 1'b1;
                if ($urandom_range(0, 3) != 0) begin
                    fr = 35'({$urandom(), $urandom()});
                    fb = fr;
                end
            end
            ciclo();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
